// File: rtl/gpu_pipe_pkg.sv
// Shared definitions for the SIMD pipeline boundary registers.
package gpu_pipe_pkg;

    // Occupancy encoding of the elastic boundary registers.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } skid_state_e;

    // LSB of operand k, lane l inside a packed operand bus.
    function automatic int slice_lsb(input int k, input int l,
                                     input int num_lanes, input int data_width);
        return (k * num_lanes + l) * data_width;
    endfunction

    // Total width of a packed operand bus.
    function automatic int data_bits(input int num_operands, input int num_lanes,
                                     input int data_width);
        return num_operands * num_lanes * data_width;
    endfunction

endpackage

// File: rtl/skid_entry_reg.sv
// One storage entry: valid bit plus opaque payload, with sync clear and load.
module skid_entry_reg #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             valid_in,
    input  logic [Width-1:0] payload_in,
    output logic             valid,
    output logic [Width-1:0] payload
);

    logic             valid_d, valid_q;
    logic [Width-1:0] payload_d, payload_q;

    // Clear wins over load; otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (clr) begin
            valid_d   = 1'b0;
            payload_d = '0;
        end else if (load) begin
            valid_d   = valid_in;
            payload_d = payload_in;
        end
    end

    // Entry register with asynchronous reset to empty/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid   = valid_q;
    assign payload = payload_q;

endmodule

// File: rtl/rf_ex_skid_reg.sv
// Register-read -> execute elastic boundary with a 2-entry skid buffer.
//  state    | meaning
//  ST_EMPTY | no entry valid
//  ST_ONE   | main entry valid, drives outputs
//  ST_FULL  | main and skid valid, upstream stalled
module rf_ex_skid_reg
    import gpu_pipe_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int NumLanes      = 4,
    parameter int NumOperands   = 3,
    parameter int CtrlWidth     = 64,
    parameter int StallCntWidth = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sclr,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CtrlWidth-1:0]                    in_ctrl,
    input  logic [NumLanes-1:0]                     in_mask,
    input  logic [NumOperands*NumLanes*DataWidth-1:0] in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [CtrlWidth-1:0]                    out_ctrl,
    output logic [NumLanes-1:0]                     out_mask,
    output logic [NumOperands*NumLanes*DataWidth-1:0] out_data,
    output logic [1:0]                              occupancy,
    output logic [StallCntWidth-1:0]                stall_cnt
);

    localparam int DataBits = data_bits(NumOperands, NumLanes, DataWidth);
    localparam int PayW     = CtrlWidth + NumLanes + DataBits;

    logic [DataBits-1:0] masked_data;
    logic [PayW-1:0]     in_payload;

    // Inactive lanes are zeroed on capture so execute never sees stale data.
    for (genvar k = 0; k < NumOperands; k++) begin : g_op
        for (genvar l = 0; l < NumLanes; l++) begin : g_lane
            localparam int Lsb = slice_lsb(k, l, NumLanes, DataWidth);
            assign masked_data[Lsb +: DataWidth] =
                in_mask[l] ? in_data[Lsb +: DataWidth] : '0;
        end
    end

    assign in_payload = {in_ctrl, in_mask, masked_data};

    skid_state_e     state_d, state_q;
    logic            main_valid, skid_valid;
    logic [PayW-1:0] main_payload, skid_payload;
    logic            main_load, main_vin, skid_load, skid_vin;
    logic [PayW-1:0] main_pin, skid_pin;
    logic            accept, release_w;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign release_w = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state and entry load controls.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_vin  = main_valid;
        main_pin  = in_payload;
        skid_load = 1'b0;
        skid_vin  = 1'b0;
        skid_pin  = in_payload;
        if (sclr) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        main_vin  = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && release_w) begin
                        main_load = 1'b1;
                        main_vin  = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        skid_vin  = 1'b1;
                        state_d   = ST_FULL;
                    end else if (release_w) begin
                        // Payload kept so outputs do not change while invalid.
                        main_load = 1'b1;
                        main_vin  = 1'b0;
                        main_pin  = main_payload;
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (release_w) begin
                        main_load = 1'b1;
                        main_vin  = 1'b1;
                        main_pin  = skid_payload;
                        skid_load = 1'b1;
                        skid_vin  = 1'b0;
                        skid_pin  = '0;
                        state_d   = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    skid_entry_reg #(.Width(PayW)) u_main (
        .clk        (clk),
        .rst        (rst),
        .clr        (sclr),
        .load       (main_load),
        .valid_in   (main_vin),
        .payload_in (main_pin),
        .valid      (main_valid),
        .payload    (main_payload)
    );

    skid_entry_reg #(.Width(PayW)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clr        (sclr),
        .load       (skid_load),
        .valid_in   (skid_vin),
        .payload_in (skid_pin),
        .valid      (skid_valid),
        .payload    (skid_payload)
    );

    assign {out_ctrl, out_mask, out_data} = main_payload;
    assign occupancy = state_q;

    logic [StallCntWidth-1:0] stall_cnt_d, stall_cnt_q;

    // Saturating count of cycles where execute holds off a valid instruction.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (sclr)
            stall_cnt_d = '0;
        else if (out_valid && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule
